// File: rtl/rc4_prga.sv
// RC4 keystream generator and message decrypter: walks S with the i/j swap,
// XORs each keystream byte with the encrypted ROM and flags non-alphabetic plaintext.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | waiting for start
// RD_SI    | drive S[i+1], advance i
// WT_SI    | hold address for read latency
// LATCH_SI | capture si, j <= j + si
// RD_SJ    | drive S[j]
// WT_SJ    | hold address for read latency
// LATCH_SJ | capture sj
// WR_SI    | S[i] <= sj
// WR_SJ    | S[j] <= si
// RD_F     | drive S[si+sj] and enc[k]
// WT_F     | hold addresses for read latency
// LATCH_F  | capture keystream byte f and encrypted byte
// WR_DEC   | dec[k] <= f ^ enc, check validity
// NEXT     | abort, finish or advance k
// DONE     | one-cycle done pulse
module rc4_prga #(
  parameter int MSG_LEN          = 32,
  parameter int MSG_AW           = 5,
  parameter int ABORT_ON_INVALID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              invalid,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        s_rddata,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rddata,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_wrdata,
  output logic              dec_wren
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] RD_SI    = 4'd1;
  localparam logic [3:0] WT_SI    = 4'd2;
  localparam logic [3:0] LATCH_SI = 4'd3;
  localparam logic [3:0] RD_SJ    = 4'd4;
  localparam logic [3:0] WT_SJ    = 4'd5;
  localparam logic [3:0] LATCH_SJ = 4'd6;
  localparam logic [3:0] WR_SI    = 4'd7;
  localparam logic [3:0] WR_SJ    = 4'd8;
  localparam logic [3:0] RD_F     = 4'd9;
  localparam logic [3:0] WT_F     = 4'd10;
  localparam logic [3:0] LATCH_F  = 4'd11;
  localparam logic [3:0] WR_DEC   = 4'd12;
  localparam logic [3:0] NEXT     = 4'd13;
  localparam logic [3:0] DONE     = 4'd14;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  logic [3:0]        state;
  logic [7:0]        i, j, si, sj, f, enc;
  logic [MSG_AW-1:0] k;
  logic              byte_bad;
  logic [7:0]        plain;
  logic              plain_ok;

  assign plain    = f ^ enc;
  assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= 8'd0;
      j        <= 8'd0;
      k        <= '0;
      si       <= 8'd0;
      sj       <= 8'd0;
      f        <= 8'd0;
      enc      <= 8'd0;
      byte_bad <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i       <= 8'd0;
            j       <= 8'd0;
            k       <= '0;
            invalid <= 1'b0;
            state   <= RD_SI;
          end
        end
        RD_SI: begin
          i     <= i + 8'd1;
          state <= WT_SI;
        end
        WT_SI:    state <= LATCH_SI;
        LATCH_SI: begin
          si    <= s_rddata;
          j     <= j + s_rddata;
          state <= RD_SJ;
        end
        RD_SJ:    state <= WT_SJ;
        WT_SJ:    state <= LATCH_SJ;
        LATCH_SJ: begin
          sj    <= s_rddata;
          state <= WR_SI;
        end
        WR_SI:    state <= WR_SJ;
        WR_SJ:    state <= RD_F;
        RD_F:     state <= WT_F;
        WT_F:     state <= LATCH_F;
        LATCH_F: begin
          f     <= s_rddata;
          enc   <= rom_rddata;
          state <= WR_DEC;
        end
        WR_DEC: begin
          byte_bad <= !plain_ok;
          if (!plain_ok) invalid <= 1'b1;
          state <= NEXT;
        end
        NEXT: begin
          if ((byte_bad && (ABORT_ON_INVALID != 0)) || (k == K_LAST)) begin
            state <= DONE;
          end else begin
            k     <= k + 1'b1;
            state <= RD_SI;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses are held through the wait and latch cycles so read data stays valid.
  always_comb begin
    busy       = (state != IDLE) && (state != DONE);
    done       = (state == DONE);
    s_addr     = 8'd0;
    s_wrdata   = 8'd0;
    s_wren     = 1'b0;
    rom_addr   = '0;
    dec_addr   = '0;
    dec_wrdata = 8'd0;
    dec_wren   = 1'b0;
    case (state)
      RD_SI:                 s_addr = i + 8'd1;
      WT_SI, LATCH_SI:       s_addr = i;
      RD_SJ, WT_SJ, LATCH_SJ: s_addr = j;
      WR_SI: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      RD_F, WT_F, LATCH_F: begin
        s_addr   = si + sj;
        rom_addr = k;
      end
      WR_DEC: begin
        dec_addr   = k;
        dec_wrdata = plain;
        dec_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_prga.sv
// Bench for rc4_prga: three instances (abort / no-abort / 32-byte) with behavioural
// memories and a software RC4 model providing every expected plaintext byte.
module tb_rc4_prga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       start [3];
  logic       busy [3];
  logic       done [3];
  logic       invalid [3];
  logic       s_wren [3];
  logic       dec_wren [3];
  logic [7:0] s_addr [3];
  logic [7:0] s_wrdata [3];
  logic [7:0] s_rddata [3];
  logic [7:0] rom_rddata [3];
  logic [7:0] dec_wrdata [3];
  logic [4:0] rom_addr [3];
  logic [4:0] dec_addr [3];
  logic       load [3];

  logic [7:0] s_mem [3][256];
  logic [7:0] rom_mem [3][32];
  logic [7:0] dec_mem [3][32];

  logic [7:0] exp_dec [3][32];
  logic [7:0] exp_s [3][256];
  int         exp_n [3];
  int         exp_inv [3];
  int         wr_cnt [3];
  int         done_cnt [3];
  int         n_cmp = 0;
  int         n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    rc4_prga #(
      .MSG_LEN((g == 2) ? 32 : 3),
      .MSG_AW(5),
      .ABORT_ON_INVALID((g == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .start(start[g]),
      .busy(busy[g]), .done(done[g]), .invalid(invalid[g]),
      .s_addr(s_addr[g]), .s_wrdata(s_wrdata[g]), .s_wren(s_wren[g]),
      .s_rddata(s_rddata[g]),
      .rom_addr(rom_addr[g]), .rom_rddata(rom_rddata[g]),
      .dec_addr(dec_addr[g]), .dec_wrdata(dec_wrdata[g]), .dec_wren(dec_wren[g])
    );
  end

  // Synchronous memories with one-cycle read latency; load restores identity S.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (load[g]) begin
        for (int n = 0; n < 256; n++) s_mem[g][n] <= 8'(n);
        for (int n = 0; n < 32; n++) dec_mem[g][n] <= 8'hEE;
      end else begin
        if (s_wren[g]) s_mem[g][s_addr[g]] <= s_wrdata[g];
        if (dec_wren[g]) dec_mem[g][dec_addr[g]] <= dec_wrdata[g];
      end
      s_rddata[g]   <= s_mem[g][s_addr[g]];
      rom_rddata[g] <= rom_mem[g][rom_addr[g]];
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Plain RC4 from an identity S over the instance's ROM contents.
  function automatic void model(input int g, input int len, input bit abort);
    logic [7:0] s [256];
    logic [7:0] i, j, t, p;
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    for (int n = 0; n < 32; n++) exp_dec[g][n] = 8'hEE;
    exp_n[g]   = 0;
    exp_inv[g] = 0;
    for (int k = 0; k < len; k++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i];
      s[i] = s[j];
      s[j] = t;
      p = s[8'(s[i] + s[j])] ^ rom_mem[g][k];
      exp_dec[g][k] = p;
      exp_n[g]++;
      if (!(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) begin
        exp_inv[g] = 1;
        if (abort) break;
      end
    end
    for (int n = 0; n < 256; n++) exp_s[g][n] = s[n];
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (load[g]) begin
          wr_cnt[g]   = 0;
          done_cnt[g] = 0;
        end else begin
          if (dec_wren[g]) begin
            check($sformatf("dec_addr[%0d]", g), int'(dec_addr[g]), wr_cnt[g]);
            if (wr_cnt[g] < 32)
              check($sformatf("dec_data[%0d] byte %0d", g, wr_cnt[g]),
                    int'(dec_wrdata[g]), int'(exp_dec[g][wr_cnt[g]]));
            wr_cnt[g]++;
          end
          if (s_wren[g] || dec_wren[g])
            check($sformatf("wren_exclusive[%0d]", g), int'(s_wren[g] && dec_wren[g]), 0);
          if (done[g]) done_cnt[g]++;
        end
      end
    end
  endtask

  task automatic run_pass(input int g, input int len, input bit abort,
                          input bit disturb, input string tag);
    int cyc;
    int bad;
    model(g, len, abort);
    load[g] = 1'b1;
    @(posedge clk); #1;
    load[g]  = 1'b0;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      start[g] = disturb && (cyc == 5 || cyc == 20 || cyc == 13 * exp_n[g] - 2);
      if (done[g]) break;
      if (cyc > 5000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s done_timeout: no done after %0d cycles", tag, cyc);
        break;
      end
    end
    start[g] = 1'b0;
    n_cmp++;
    if (cyc < 13 * exp_n[g] - 1 || cyc > 13 * exp_n[g] + 1) begin
      n_fail++;
      $display("FAIL %s cycles: got %0d, expected %0d +-1", tag, cyc, 13 * exp_n[g]);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done_count"}, done_cnt[g], 1);
    check({tag, " busy_after"}, int'(busy[g]), 0);
    check({tag, " invalid"}, int'(invalid[g]), exp_inv[g]);
    check({tag, " write_count"}, wr_cnt[g], exp_n[g]);
    for (int n = 0; n < 32; n++)
      if (n < len || n < 4)
        check($sformatf("%s dec_mem[%0d]", tag, n), int'(dec_mem[g][n]), int'(exp_dec[g][n]));
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[g][n] != exp_s[g][n]) bad++;
    check({tag, " s_mem_mismatches"}, bad, 0);
  endtask

  task automatic main_seq();
    int swc;
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; load[g] = 1'b0;
      for (int n = 0; n < 32; n++) rom_mem[g][n] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst busy[%0d]", g), int'(busy[g]), 0);
      check($sformatf("rst done[%0d]", g), int'(done[g]), 0);
      check($sformatf("rst invalid[%0d]", g), int'(invalid[g]), 0);
      check($sformatf("rst s_wren[%0d]", g), int'(s_wren[g]), 0);
      check($sformatf("rst dec_wren[%0d]", g), int'(dec_wren[g]), 0);
      check($sformatf("rst addrs[%0d]", g),
            int'(s_addr[g]) | int'(rom_addr[g]) | int'(dec_addr[g]), 0);
      check($sformatf("rst wrdata[%0d]", g), int'(s_wrdata[g]) | int'(dec_wrdata[g]), 0);
      rst[g] = 1'b0;
    end

    // Pin the model against hand-worked RC4 on identity S.
    rom_mem[0][0] = 8'h63; rom_mem[0][1] = 8'h60; rom_mem[0][2] = 8'h66;
    model(0, 3, 1'b1);
    check("model ks0", int'(exp_dec[0][0] ^ 8'h63), 8'h02);
    check("model ks1", int'(exp_dec[0][1] ^ 8'h60), 8'h05);
    check("model ks2", int'(exp_dec[0][2] ^ 8'h66), 8'h07);

    run_pass(0, 3, 1'b1, 1'b0, "basic");
    check("basic dec0 lit", int'(dec_mem[0][0]), 8'h61);
    check("basic dec1 lit", int'(dec_mem[0][1]), 8'h65);
    check("basic dec2 lit", int'(dec_mem[0][2]), 8'h61);
    check("basic S2 lit", int'(s_mem[0][2]), 8'h03);
    check("basic S3 lit", int'(s_mem[0][3]), 8'h05);
    check("basic S5 lit", int'(s_mem[0][5]), 8'h02);
    check("basic S7 lit", int'(s_mem[0][7]), 8'h07);

    rom_mem[0][1] = 8'h00;
    run_pass(0, 3, 1'b1, 1'b0, "abort");
    check("abort dec1 lit", int'(dec_mem[0][1]), 8'h05);
    check("abort dec2 untouched", int'(dec_mem[0][2]), 8'hEE);

    rom_mem[1][0] = 8'h63; rom_mem[1][1] = 8'h00; rom_mem[1][2] = 8'h66;
    run_pass(1, 3, 1'b0, 1'b0, "noabort");
    check("noabort dec2 lit", int'(dec_mem[1][2]), 8'h61);

    // Reset during the S[j] write of byte 1.
    rom_mem[0][1] = 8'h60;
    model(0, 3, 1'b1);
    load[0] = 1'b1;
    @(posedge clk); #1;
    load[0]  = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    swc = 0;
    for (int c = 0; c < 200 && swc < 4; c++) begin
      @(posedge clk); #1;
      if (s_wren[0]) swc++;
    end
    check("midreset wr_sj reached", swc, 4);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", int'(busy[0]), 0);
    check("midreset s_wren", int'(s_wren[0]), 0);
    check("midreset dec_wren", int'(dec_wren[0]), 0);
    check("midreset dec writes", wr_cnt[0], 1);
    rst[0] = 1'b0;
    run_pass(0, 3, 1'b1, 1'b0, "after_reset");

    run_pass(0, 3, 1'b1, 1'b1, "start_while_busy");

    run_pass(2, 32, 1'b0, 1'b0, "len32");
    check("len32 dec0 lit", int'(dec_mem[2][0]), 8'h02);
    check("len32 dec1 lit", int'(dec_mem[2][1]), 8'h05);
    check("len32 dec2 lit", int'(dec_mem[2][2]), 8'h07);
  endtask

  initial begin
    fork
      monitor();
      main_seq();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
